// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel receiver with a one-word holding register on a valid/ready port.
// Latency: word visible the cycle after its last bit; back-pressure drops the new word and pulses overrun.
// Optional even-parity frame bit when SIPO_PARITY_EN is defined; parity_err is tied to 0 otherwise.
module sipo_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             din,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             parity_err,
    output logic [CNT_W-1:0] bit_cnt
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    // The shift register only needs FRAME-1 bits: the last bit is taken straight from din.
    localparam int SR_W = FRAME - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_nxt;
    logic [SR_W-1:0]  shift_reg;
    logic [FRAME-1:0] frame;
    logic             frame_done;
    logic             load;
    logic             drop;

    assign frame      = {din, shift_reg};
    assign frame_done = enable && (bit_cnt == LAST);
    assign out_valid  = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (enable) begin
            shift_reg <= frame[FRAME-1:1];
            bit_cnt   <= frame_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (frame_done) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (frame_done) begin
                    // A same-edge consume frees the slot for the new word.
                    if (out_ready) load = 1'b1;
                    else           drop = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            overrun  <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= drop;
            if (load) out_data <= frame[WIDTH-1:0];
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^frame;
        end else if (out_valid && out_ready) begin
            parity_q <= 1'b0;
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
